// File: rtl/pe.sv
// Weight-stationary systolic array processing element.
// Signed MAC into a local accumulator, forwarding of activations and weights, and partial-sum chaining.
module pe #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load_weight,
    input  logic                  clear_acc,
    input  logic                  acc_enable,
    input  logic [DATA_WIDTH-1:0] in_left,
    input  logic [DATA_WIDTH-1:0] in_top,
    input  logic [ACC_WIDTH-1:0]  partial_sum_in,
    output logic [DATA_WIDTH-1:0] out_right,
    output logic [DATA_WIDTH-1:0] out_bottom,
    output logic [ACC_WIDTH-1:0]  partial_sum_out
);

    logic signed [DATA_WIDTH-1:0]   weight_reg;
    logic signed [ACC_WIDTH-1:0]    accumulator;
    logic signed [ACC_WIDTH-1:0]    mac_result;
    logic signed [2*DATA_WIDTH-1:0] product;
    logic                           fire;

    assign product    = weight_reg * $signed(in_left);
    assign mac_result = ACC_WIDTH'(product);

    // out_right holds the last forwarded operand, so a repeated value is not counted twice
    assign fire = enable & acc_enable & (in_left != out_right);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            weight_reg      <= '0;
            accumulator     <= '0;
            out_right       <= '0;
            out_bottom      <= '0;
            partial_sum_out <= '0;
        end else begin
            if (load_weight) begin
                weight_reg <= in_top;
            end
            if (clear_acc) begin
                accumulator <= '0;
            end else if (fire) begin
                accumulator <= accumulator + mac_result;
            end
            if (enable) begin
                out_right       <= in_left;
                out_bottom      <= in_top;
                partial_sum_out <= partial_sum_in + accumulator;
            end
        end
    end

endmodule

// File: tb/tb_pe.sv
// Directed self-checking bench for the systolic array PE.
// Expected values are hand-computed constants.
module tb_pe;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load_weight;
    logic        clear_acc;
    logic        acc_enable;
    logic [15:0] in_left;
    logic [15:0] in_top;
    logic [31:0] partial_sum_in;
    logic [15:0] out_right;
    logic [15:0] out_bottom;
    logic [31:0] partial_sum_out;

    int total;
    int bad;

    pe #(.DATA_WIDTH(16), .ACC_WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .load_weight    (load_weight),
        .clear_acc      (clear_acc),
        .acc_enable     (acc_enable),
        .in_left        (in_left),
        .in_top         (in_top),
        .partial_sum_in (partial_sum_in),
        .out_right      (out_right),
        .out_bottom     (out_bottom),
        .partial_sum_out(partial_sum_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        enable = 1'b0;
        load_weight = 1'b0;
        clear_acc = 1'b0;
        acc_enable = 1'b0;
        in_left = 16'h0;
        in_top = 16'h0;
        partial_sum_in = 32'h0;
        #1;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("rst_out_right", 32'(out_right), 32'h0);
        check("rst_out_bottom", 32'(out_bottom), 32'h0);
        check("rst_psum", partial_sum_out, 32'h0);
        check("rst_acc", dut.accumulator, 32'h0);
        check("rst_weight", 32'(dut.weight_reg), 32'h0);

        // weight load with enable low
        load_weight = 1'b1;
        in_top = 16'd5;
        step();
        load_weight = 1'b0;
        check("load_w5", 32'(dut.weight_reg), 32'd5);
        check("dis_bottom_hold", 32'(out_bottom), 32'h0);

        // fire once per new operand
        in_top = 16'd0;
        enable = 1'b1;
        acc_enable = 1'b1;
        in_left = 16'd3;
        step();
        check("mac_first", dut.accumulator, 32'd15);
        step();
        check("mac_repeat_hold", dut.accumulator, 32'd15);
        check("fwd_right3", 32'(out_right), 32'd3);
        in_left = 16'd4;
        step();
        check("mac_second", dut.accumulator, 32'd35);

        // clear with unchanged operand
        clear_acc = 1'b1;
        step();
        clear_acc = 1'b0;
        check("clear", dut.accumulator, 32'd0);
        step();
        check("clear_stays", dut.accumulator, 32'd0);

        // forwarding
        in_left = 16'd100;
        in_top = 16'd200;
        step();
        check("fwd_right", 32'(out_right), 32'd100);
        check("fwd_bottom", 32'(out_bottom), 32'd200);
        check("fwd_acc", dut.accumulator, 32'd500);

        // enable low: no fire, forwarding holds
        enable = 1'b0;
        in_left = 16'd7;
        in_top = 16'd9;
        step();
        check("dis_right_hold", 32'(out_right), 32'd100);
        check("dis_bottom_hold2", 32'(out_bottom), 32'd200);
        check("dis_acc_hold", dut.accumulator, 32'd500);
        enable = 1'b1;

        // signed: -5 * -3
        acc_enable = 1'b0;
        clear_acc = 1'b1;
        load_weight = 1'b1;
        in_top = 16'hFFFB;
        step();
        clear_acc = 1'b0;
        load_weight = 1'b0;
        acc_enable = 1'b1;
        in_left = 16'hFFFD;
        #1;
        check("mac_signed", dut.mac_result, 32'd15);
        step();
        check("acc_signed", dut.accumulator, 32'd15);

        // alternating extremes with weight 0x7FFF
        acc_enable = 1'b0;
        clear_acc = 1'b1;
        load_weight = 1'b1;
        in_top = 16'h7FFF;
        step();
        clear_acc = 1'b0;
        load_weight = 1'b0;
        acc_enable = 1'b1;
        in_left = 16'h8000;
        step();
        check("alt1", dut.accumulator, 32'hC0008000);
        in_left = 16'h7FFF;
        step();
        check("alt2", dut.accumulator, 32'hFFFF8001);
        in_left = 16'h8000;
        step();
        check("alt3", dut.accumulator, 32'hC0000001);

        // positive products overflow the signed range
        acc_enable = 1'b0;
        clear_acc = 1'b1;
        step();
        clear_acc = 1'b0;
        acc_enable = 1'b1;
        in_left = 16'h7FFF;
        step();
        in_left = 16'h7FFE;
        step();
        in_left = 16'h7FFF;
        step();
        check("wrap_mid", dut.accumulator, 32'hBFFC8004);
        in_left = 16'h7FFE;
        step();
        check("wrap_end", dut.accumulator, 32'hFFFB0006);

        // load and fire together use the old weight
        acc_enable = 1'b0;
        clear_acc = 1'b1;
        load_weight = 1'b1;
        in_top = 16'd3;
        step();
        clear_acc = 1'b0;
        acc_enable = 1'b1;
        in_top = 16'd9;
        in_left = 16'd2;
        step();
        load_weight = 1'b0;
        check("old_weight_acc", dut.accumulator, 32'd6);
        check("new_weight", 32'(dut.weight_reg), 32'd9);

        // partial sum chaining
        acc_enable = 1'b0;
        clear_acc = 1'b1;
        load_weight = 1'b1;
        in_top = 16'd2;
        step();
        clear_acc = 1'b0;
        load_weight = 1'b0;
        acc_enable = 1'b1;
        partial_sum_in = 32'd100;
        in_left = 16'd5;
        step();
        check("psum_acc", dut.accumulator, 32'd10);
        check("psum_first", partial_sum_out, 32'd100);
        step();
        check("psum_second", partial_sum_out, 32'd110);

        // reset mid-accumulation
        in_left = 16'd7;
        rst_n = 1'b0;
        step();
        check("mid_rst_acc", dut.accumulator, 32'h0);
        check("mid_rst_weight", 32'(dut.weight_reg), 32'h0);
        check("mid_rst_right", 32'(out_right), 32'h0);
        check("mid_rst_bottom", 32'(out_bottom), 32'h0);
        check("mid_rst_psum", partial_sum_out, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
